// File: rtl/axi_wr_region_sched.sv
// Write-beat scheduler: queues internal AXI write beats and issues them one at a
// time to IRAM, WRAM or the input FIFO, reporting completion, error or timeout.
module axi_wr_region_sched #(
    parameter int QDEPTH      = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axi_wr_vld,
    output logic             axi_wr_rdy,
    input  logic [10:0]      axi_wr_addr,
    input  logic [31:0]      axi_wr_data,
    input  logic [3:0]       axi_wr_strb,
    input  logic [1:0]       axi_wr_region,
    output logic             iram_wr_en,
    output logic             wram_wr_en,
    output logic             fifo_wr_en,
    output logic [10:0]      tgt_addr,
    output logic [31:0]      tgt_data,
    output logic [3:0]       tgt_strb,
    input  logic             iram_wr_done,
    input  logic             wram_wr_done,
    input  logic             fifo_wr_done,
    input  logic             fifo_err,
    output logic             sched_done,
    output logic             sched_err,
    output logic [1:0]       sched_err_code,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] RG_IRAM = 2'b00;
    localparam logic [1:0] RG_WRAM = 2'b01;
    localparam logic [1:0] RG_FIFO = 2'b10;
    localparam logic [1:0] RG_BAD  = 2'b11;

    localparam logic [1:0] EC_OK      = 2'b00;
    localparam logic [1:0] EC_REGION  = 2'b01;
    localparam logic [1:0] EC_TARGET  = 2'b10;
    localparam logic [1:0] EC_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Entry layout: {addr[48:38], data[37:6], strb[5:2], region[1:0]}
    logic [48:0]   q_mem_r [QDEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic [48:0]   head_s;
    logic          push_s;
    logic          pop_s;

    state_t        state_r;
    logic [1:0]    region_r;
    logic [1:0]    code_r;
    logic [TW-1:0] timer_r;
    logic          rsp_done_s;
    logic          rsp_err_s;
    logic          fin_s;
    logic [1:0]    fin_code_s;

    assign axi_wr_rdy = (count_r < QFULL);
    assign push_s     = axi_wr_vld && axi_wr_rdy;
    assign pop_s      = (state_r == ST_IDLE) && (count_r != '0);
    assign head_s     = q_mem_r[rptr_r];
    assign busy       = (state_r != ST_IDLE) || (count_r != '0);

    // Queue storage write; contents are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_mem_r[wptr_r] <= {axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) wptr_r <= wptr_r + PW'(1);
            if (pop_s)  rptr_r <= rptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response decode: only the issued target is listened to, and fifo_err beats done.
    always_comb begin
        rsp_done_s = 1'b0;
        rsp_err_s  = (region_r == RG_FIFO) && fifo_err;
        fin_s      = 1'b0;
        fin_code_s = EC_OK;
        case (region_r)
            RG_IRAM: rsp_done_s = iram_wr_done;
            RG_WRAM: rsp_done_s = wram_wr_done;
            RG_FIFO: rsp_done_s = fifo_wr_done;
            default: rsp_done_s = 1'b0;
        endcase
        case (state_r)
            ST_ISSUE: begin
                if (region_r == RG_BAD) begin
                    fin_s      = 1'b1;
                    fin_code_s = EC_REGION;
                end else if (rsp_err_s) begin
                    fin_s      = 1'b1;
                    fin_code_s = EC_TARGET;
                end else if (rsp_done_s) begin
                    fin_s      = 1'b1;
                    fin_code_s = EC_OK;
                end else begin
                    fin_s      = 1'b0;
                    fin_code_s = EC_OK;
                end
            end
            ST_WAIT: begin
                if (rsp_err_s) begin
                    fin_s      = 1'b1;
                    fin_code_s = EC_TARGET;
                end else if (rsp_done_s) begin
                    fin_s      = 1'b1;
                    fin_code_s = EC_OK;
                end else if (timer_r == TLAST) begin
                    fin_s      = 1'b1;
                    fin_code_s = EC_TIMEOUT;
                end else begin
                    fin_s      = 1'b0;
                    fin_code_s = EC_OK;
                end
            end
            default: begin
                fin_s      = 1'b0;
                fin_code_s = EC_OK;
            end
        endcase
    end

    // Issue FSM with registered strobes, held target fields, result pulse and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            region_r       <= 2'b00;
            code_r         <= 2'b00;
            timer_r        <= '0;
            tgt_addr       <= 11'h000;
            tgt_data       <= 32'h0000_0000;
            tgt_strb       <= 4'h0;
            iram_wr_en     <= 1'b0;
            wram_wr_en     <= 1'b0;
            fifo_wr_en     <= 1'b0;
            sched_done     <= 1'b0;
            sched_err      <= 1'b0;
            sched_err_code <= 2'b00;
            done_cnt       <= '0;
            err_cnt        <= '0;
        end else begin
            iram_wr_en     <= 1'b0;
            wram_wr_en     <= 1'b0;
            fifo_wr_en     <= 1'b0;
            sched_done     <= 1'b0;
            sched_err      <= 1'b0;
            sched_err_code <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tgt_addr   <= head_s[48:38];
                        tgt_data   <= head_s[37:6];
                        tgt_strb   <= head_s[5:2];
                        region_r   <= head_s[1:0];
                        iram_wr_en <= (head_s[1:0] == RG_IRAM);
                        wram_wr_en <= (head_s[1:0] == RG_WRAM);
                        fifo_wr_en <= (head_s[1:0] == RG_FIFO);
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (fin_s) begin
                        state_r        <= ST_RESP;
                        code_r         <= fin_code_s;
                        sched_done     <= 1'b1;
                        sched_err      <= (fin_code_s != EC_OK);
                        sched_err_code <= fin_code_s;
                    end else if (state_r == ST_ISSUE) begin
                        state_r <= ST_WAIT;
                        timer_r <= '0;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (code_r == EC_OK) begin
                        if (done_cnt != {CNT_W{1'b1}}) done_cnt <= done_cnt + CNT_W'(1);
                    end else begin
                        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
                    end
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_region_sched.sv
// Scoreboard bench for axi_wr_region_sched: directed beats, a scripted target
// responder, and a monitor that checks every issue strobe and completion pulse.
module tb_axi_wr_region_sched;

    logic        clk;
    logic        rst;
    logic        axi_wr_vld;
    logic        axi_wr_rdy;
    logic [10:0] axi_wr_addr;
    logic [31:0] axi_wr_data;
    logic [3:0]  axi_wr_strb;
    logic [1:0]  axi_wr_region;
    logic        iram_wr_en, wram_wr_en, fifo_wr_en;
    logic [10:0] tgt_addr;
    logic [31:0] tgt_data;
    logic [3:0]  tgt_strb;
    logic        iram_wr_done, wram_wr_done, fifo_wr_done, fifo_err;
    logic        sched_done, sched_err;
    logic [1:0]  sched_err_code;
    logic        busy;
    logic [15:0] done_cnt, err_cnt;

    axi_wr_region_sched #(.QDEPTH(2), .TIMEOUT_CYC(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .axi_wr_vld(axi_wr_vld), .axi_wr_rdy(axi_wr_rdy),
        .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
        .axi_wr_strb(axi_wr_strb), .axi_wr_region(axi_wr_region),
        .iram_wr_en(iram_wr_en), .wram_wr_en(wram_wr_en), .fifo_wr_en(fifo_wr_en),
        .tgt_addr(tgt_addr), .tgt_data(tgt_data), .tgt_strb(tgt_strb),
        .iram_wr_done(iram_wr_done), .wram_wr_done(wram_wr_done),
        .fifo_wr_done(fifo_wr_done), .fifo_err(fifo_err),
        .sched_done(sched_done), .sched_err(sched_err), .sched_err_code(sched_err_code),
        .busy(busy), .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  code;
        int          lat;     // done cycle minus issue cycle, -1 = not checked
    } exp_t;

    typedef struct packed {
        int dly;              // cycles after the issue cycle, -1 = never respond
        bit err;
        bit noise;            // also pulse iram_wr_done one cycle into WAIT
    } rsp_t;

    exp_t        exp_q[$];
    int          en_q[$];
    rsp_t        rsp_q[$];
    string       pt_name[$];
    logic [31:0] pt_act[$];
    logic [31:0] pt_exp[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    int last_en_cyc = 0;
    int last_done_cyc = 0;
    int push_cyc = 0;
    bit inj_wram = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pt(input string nm, input logic [31:0] act, input logic [31:0] exp);
        pt_name.push_back(nm);
        pt_act.push_back(act);
        pt_exp.push_back(exp);
    endtask

    // Monitor: every issue strobe and completion pulse is matched to the scoreboard.
    initial begin
        int   n_en;
        int   kind;
        int   e_kind;
        exp_t e;
        forever begin
            @(negedge clk);
            n_en = int'(iram_wr_en) + int'(wram_wr_en) + int'(fifo_wr_en);
            if (n_en > 0) begin
                chk("en_onehot", 32'(n_en <= 1), 32'd1);
                kind = wram_wr_en ? 1 : (fifo_wr_en ? 2 : 0);
                chk("en_expected", 32'(en_q.size() > 0), 32'd1);
                if (en_q.size() > 0) begin
                    e_kind = en_q.pop_front();
                    chk("en_target", 32'(kind), 32'(e_kind));
                end
                last_en_cyc = cyc;
            end
            if (sched_done) begin
                done_seen = done_seen + 1;
                last_done_cyc = cyc;
                chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("tgt_addr", 32'(tgt_addr), 32'(e.addr));
                    chk("tgt_data", tgt_data, e.data);
                    chk("tgt_strb", 32'(tgt_strb), 32'(e.strb));
                    chk("err_code", 32'(sched_err_code), 32'(e.code));
                    chk("sched_err", 32'(sched_err), 32'(e.code != 2'b00));
                    if (e.lat >= 0) chk("latency", 32'(cyc - last_en_cyc), 32'(e.lat));
                end
            end
            while (pt_name.size() > 0) begin
                chk(pt_name.pop_front(), pt_act.pop_front(), pt_exp.pop_front());
            end
        end
    end

    // Target model: answers each issued beat according to the scripted response queue.
    initial begin
        int   kind;
        int   cnt;
        int   ncnt;
        bit   active;
        bit   fire;
        rsp_t cur;
        iram_wr_done = 1'b0; wram_wr_done = 1'b0; fifo_wr_done = 1'b0; fifo_err = 1'b0;
        kind = 0; cnt = 0; ncnt = -1; active = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (iram_wr_en || wram_wr_en || fifo_wr_en) begin
                kind = wram_wr_en ? 1 : (fifo_wr_en ? 2 : 0);
                if (rsp_q.size() > 0) begin
                    cur    = rsp_q.pop_front();
                    active = (cur.dly >= 0);
                    cnt    = cur.dly;
                    ncnt   = cur.noise ? 1 : -1;
                end else begin
                    active = 1'b0;
                    ncnt   = -1;
                end
            end else begin
                if (active) cnt = cnt - 1;
                if (ncnt >= 0) ncnt = ncnt - 1;
            end
            fire = active && (cnt == 0);
            iram_wr_done = (fire && kind == 0) || (ncnt == 0);
            wram_wr_done = (fire && kind == 1) || inj_wram;
            fifo_wr_done = fire && kind == 2;
            fifo_err     = fire && kind == 2 && cur.err;
            if (fire) active = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] rg, input bit want_done, input logic [1:0] code,
                               input int lat, input int dly, input bit err, input bit noise);
        exp_t e;
        rsp_t r;
        e.addr = a; e.data = d; e.strb = s; e.code = code; e.lat = lat;
        r.dly = dly; r.err = err; r.noise = noise;
        if (want_done) exp_q.push_back(e);
        if (rg != 2'b11) begin
            en_q.push_back(int'(rg));
            rsp_q.push_back(r);
        end
    endtask

    task automatic push(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] rg, output logic first_rdy);
        logic acc;
        acc = 1'b0;
        first_rdy = 1'b0;
        axi_wr_vld = 1'b1; axi_wr_addr = a; axi_wr_data = d; axi_wr_strb = s; axi_wr_region = rg;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            acc = axi_wr_rdy;
            if (k == 0) first_rdy = acc;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        push_cyc = cyc;
        pt("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (done_seen < n && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        pt("wait_done", 32'(done_seen), 32'(n));
    endtask

    initial begin
        logic        fr;
        logic [10:0] a5 [5];
        logic [1:0]  r5 [5];
        int          d5 [5];
        int          t;
        int          seen;
        a5 = '{11'h100, 11'h101, 11'h102, 11'h103, 11'h104};
        r5 = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        d5 = '{5, 4, 2, 1, 0};
        rst = 1'b1; axi_wr_vld = 1'b0; axi_wr_addr = 11'h000; axi_wr_data = 32'h0;
        axi_wr_strb = 4'h0; axi_wr_region = 2'b00;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        pt("rst_rdy", 32'(axi_wr_rdy), 32'd1);
        pt("rst_busy", 32'(busy), 32'd0);
        pt("rst_done_cnt", 32'(done_cnt), 32'd0);
        pt("rst_err_cnt", 32'(err_cnt), 32'd0);
        pt("rst_tgt_addr", 32'(tgt_addr), 32'd0);
        step(1);

        // IRAM beat answered in the ISSUE cycle.
        expect_beat(11'h001, 32'd404, 4'hF, 2'b00, 1'b1, 2'b00, 1, 0, 1'b0, 1'b0);
        push(11'h001, 32'd404, 4'hF, 2'b00, fr);
        axi_wr_vld = 1'b0;
        t = push_cyc;
        wait_done(1, 50);
        // cyc holds the number of the last edge: the ISSUE cycle runs from edge T+1 to T+2.
        pt("t1_issue_cyc", 32'(last_en_cyc), 32'(t + 1));
        pt("t1_done_cyc", 32'(last_done_cyc), 32'(t + 2));
        step(2);
        pt("t1_done_cnt", 32'(done_cnt), 32'd1);
        pt("t1_err_cnt", 32'(err_cnt), 32'd0);
        pt("t1_busy", 32'(busy), 32'd0);

        // Invalid region: no strobe, code 01.
        expect_beat(11'h7FF, 32'hDEAD_BEEF, 4'h3, 2'b11, 1'b1, 2'b01, -1, 0, 1'b0, 1'b0);
        push(11'h7FF, 32'hDEAD_BEEF, 4'h3, 2'b11, fr);
        axi_wr_vld = 1'b0;
        wait_done(2, 50);
        step(2);
        pt("t2_err_cnt", 32'(err_cnt), 32'd1);
        pt("t2_done_cnt", 32'(done_cnt), 32'd1);

        // FIFO beat: done and error together, error wins.
        expect_beat(11'h123, 32'h0BAD_F00D, 4'h5, 2'b10, 1'b1, 2'b10, 5, 4, 1'b1, 1'b0);
        push(11'h123, 32'h0BAD_F00D, 4'h5, 2'b10, fr);
        axi_wr_vld = 1'b0;
        wait_done(3, 50);
        step(2);
        pt("t3_err_cnt", 32'(err_cnt), 32'd2);
        pt("t3_done_cnt", 32'(done_cnt), 32'd1);

        // WRAM timeout: 64 WAIT cycles, so RESP is 65 cycles after ISSUE.
        expect_beat(11'h2AA, 32'h1234_5678, 4'hC, 2'b01, 1'b1, 2'b11, 65, -1, 1'b0, 1'b0);
        push(11'h2AA, 32'h1234_5678, 4'hC, 2'b01, fr);
        axi_wr_vld = 1'b0;
        wait_done(4, 200);
        step(2);
        inj_wram = 1'b1;
        step(1);
        inj_wram = 1'b0;
        step(10);
        pt("t4_no_extra", 32'(done_seen), 32'd4);
        pt("t4_err_cnt", 32'(err_cnt), 32'd3);

        // Five beats back to back; the fourth finds the queue full.
        for (int i = 0; i < 5; i++) begin
            expect_beat(a5[i], 32'(i * 17 + 3), 4'hF, r5[i], 1'b1, 2'b00, d5[i] + 1, d5[i],
                        1'b0, r5[i] == 2'b01);
        end
        for (int i = 0; i < 5; i++) begin
            push(a5[i], 32'(i * 17 + 3), 4'hF, r5[i], fr);
            if (i == 3) pt("t5_rdy_full", 32'(fr), 32'd0);
        end
        axi_wr_vld = 1'b0;
        wait_done(9, 300);
        step(2);
        pt("t5_done_cnt", 32'(done_cnt), 32'd6);
        pt("t5_err_cnt", 32'(err_cnt), 32'd3);

        // Reset while waiting on WRAM with two beats queued behind it.
        expect_beat(11'h010, 32'h0, 4'h1, 2'b01, 1'b0, 2'b00, -1, -1, 1'b0, 1'b0);
        push(11'h010, 32'h0, 4'h1, 2'b01, fr);
        push(11'h011, 32'h1, 4'h2, 2'b00, fr);
        push(11'h012, 32'h2, 4'h4, 2'b10, fr);
        axi_wr_vld = 1'b0;
        step(3);
        pt("t6_pre_busy", 32'(busy), 32'd1);
        pt("t6_pre_rdy", 32'(axi_wr_rdy), 32'd0);
        seen = done_seen;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        pt("t6_rdy", 32'(axi_wr_rdy), 32'd1);
        pt("t6_busy", 32'(busy), 32'd0);
        pt("t6_done_cnt", 32'(done_cnt), 32'd0);
        pt("t6_err_cnt", 32'(err_cnt), 32'd0);
        pt("t6_outs", {25'd0, iram_wr_en, wram_wr_en, fifo_wr_en, sched_done, sched_err,
                       sched_err_code}, 32'd0);
        pt("t6_tgt", {tgt_addr, 17'd0, tgt_strb} | tgt_data, 32'd0);
        step(2);
        inj_wram = 1'b1;
        step(1);
        inj_wram = 1'b0;
        step(20);
        pt("t6_no_done", 32'(done_seen), 32'(seen));

        expect_beat(11'h055, 32'hA5A5_5A5A, 4'h9, 2'b00, 1'b1, 2'b00, 1, 0, 1'b0, 1'b0);
        push(11'h055, 32'hA5A5_5A5A, 4'h9, 2'b00, fr);
        axi_wr_vld = 1'b0;
        wait_done(seen + 1, 50);
        step(2);
        pt("t6_post_done_cnt", 32'(done_cnt), 32'd1);
        pt("end_exp_empty", 32'(exp_q.size()), 32'd0);
        pt("end_en_empty", 32'(en_q.size()), 32'd0);

        for (int k = 0; k < 10 && pt_name.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_region_sched.md
Name: axi_wr_region_sched

Overview:
Scheduler between the AXI write interface's internal write port and the three write targets: IRAM, WRAM and the input FIFO. It buffers incoming internal write beats in a small queue and issues them one at a time to the target selected by region. It waits for that target's done or error, or a timeout, and returns a one-cycle completion or error pulse to the AXI write interface. It also keeps saturating completion and error counters for debug.

Parameters:
QDEPTH, 2, depth of the input beat queue in entries (power of two, ≥2)
TIMEOUT_CYC, 64, maximum cycles spent in WAIT before a timeout error is declared (≥2)
CNT_W, 16, width of the debug counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
axi_wr_vld  in  1  internal write beat valid
axi_wr_rdy  out  1  queue can accept a beat: count<QDEPTH, combinational from registered count
axi_wr_addr  in  11  word address
axi_wr_data  in  32  write data
axi_wr_strb  in  4  byte strobes
axi_wr_region  in  2  target: 00 IRAM, 01 WRAM, 10 FIFO, 11 invalid
iram_wr_en  out  1  one-cycle issue strobe to IRAM
wram_wr_en  out  1  one-cycle issue strobe to WRAM
fifo_wr_en  out  1  one-cycle issue strobe to FIFO
tgt_addr  out  11  address for the issued beat, held ISSUE through RESP
tgt_data  out  32  data, held likewise
tgt_strb  out  4  strobes, held likewise
iram_wr_done  in  1  IRAM completion pulse
wram_wr_done  in  1  WRAM completion pulse
fifo_wr_done  in  1  FIFO completion pulse
fifo_err  in  1  FIFO error (overflow)
sched_done  out  1  one-cycle completion pulse to AXI interface
sched_err  out  1  qualifies sched_done: beat failed
sched_err_code  out  2  valid with sched_done: 00 ok, 01 bad region, 10 target error, 11 timeout
busy  out  1  FSM not IDLE or queue non-empty
done_cnt  out  CNT_W  successful beats, saturating
err_cnt  out  CNT_W  failed beats, saturating

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs go to 0 on the next cycle, except axi_wr_rdy=1 (queue empty).
  - Queue is flushed, FSM goes to IDLE, timeout counter and debug counters are cleared.
  - Any in-flight beat is dropped with no sched_done. A target done arriving after reset is ignored.
- Queue push: on an edge with axi_wr_vld&axi_wr_rdy, {addr,data,strb,region} is written at the write pointer.
  - When full, axi_wr_rdy=0 and vld is ignored. There is no pass-through when full.
  - A simultaneous push and pop is legal when not full; count is unchanged.
  - Pointers wrap modulo QDEPTH.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if queue non-empty, latch the head entry into the tgt_* registers, pop it, and go to ISSUE.
  - ISSUE (exactly 1 cycle): assert the one en selected by region.
    - Region 11: no en; record code 01 and go to RESP.
    - Otherwise, if the selected target's done or err is already high this cycle, record the result and go to RESP; else go to WAIT with timer=0.
  - WAIT: increment timer every cycle. Only the selected target's done (and fifo_err only when region=10) is honoured; done from other targets is ignored.
    - Done with no error: code 00.
    - fifo_err (with or without fifo_wr_done): code 10. Error wins over simultaneous done.
    - Timer reaches TIMEOUT_CYC-1 with no response: code 11.
    - Any of these go to RESP.
  - RESP (1 cycle): sched_done=1; sched_err=(code!=00); sched_err_code=code; increment done_cnt or err_cnt (saturating at all-ones). Then go to IDLE.
- Latency: a beat pushed at edge T reaches ISSUE in cycle T+2. With a same-cycle done, sched_done is in cycle T+3. Back-to-back throughput is 1 beat per 3 cycles minimum.
- At most one en is high at any time. Ens are never asserted outside ISSUE.
- tgt_* hold steady from ISSUE through RESP.

Test Plan:
- Reset, then push {addr=0x001, data=404, strb=F, region=00}; iram_wr_done high in ISSUE → iram_wr_en for 1 cycle at T+2, sched_done=1, err=0, code 00 at T+3, done_cnt=1.
- Region 11 beat → no en asserted, sched_done with sched_err=1, code 01, err_cnt=1.
- FIFO beat, fifo_wr_done and fifo_err both high 3 cycles into WAIT → code 10, err_cnt increments, done_cnt unchanged.
- WRAM beat, no done, with TIMEOUT_CYC=64 → sched_done with code 11 exactly 64 cycles after entering WAIT. A late wram_wr_done afterwards is ignored with no extra pulse.
- Hold vld high for 5 beats with delayed dones → axi_wr_rdy drops when 2 entries are queued. All 5 complete in order with matching tgt_addr. iram_wr_done asserted during a WRAM WAIT is ignored.
- Assert rst while in WAIT with 2 entries queued → next cycle all outputs are 0, axi_wr_rdy=1, counters are 0, and no sched_done appears for the dropped beats.
